// File: rtl/foc_loop_sched.sv
// FOC loop sequencer: loads d/q PID coefficients, then issues one datapath
// transaction per sample period with overrun and ready-timeout detection.
module foc_loop_sched #(
    parameter int D_WIDTH  = 19,
    parameter int Q_BITS   = 15,
    parameter int PERIOD_W = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                cfg_start,
    input  logic [D_WIDTH-1:0]  cfg_kp_d,
    input  logic [D_WIDTH-1:0]  cfg_ki_d,
    input  logic [D_WIDTH-1:0]  cfg_kp_q,
    input  logic [D_WIDTH-1:0]  cfg_ki_q,
    output logic                cfg_busy,
    output logic                configured,
    output logic                pid_d_wen,
    output logic                pid_q_wen,
    output logic [D_WIDTH-1:0]  pid_d_addr,
    output logic [D_WIDTH-1:0]  pid_q_addr,
    output logic [D_WIDTH-1:0]  pid_d_data,
    output logic [D_WIDTH-1:0]  pid_q_data,
    input  logic [D_WIDTH-1:0]  angle_in,
    input  logic [D_WIDTH-1:0]  currA_in,
    input  logic [D_WIDTH-1:0]  currB_in,
    input  logic [D_WIDTH-1:0]  currC_in,
    output logic [D_WIDTH-1:0]  angle_out,
    output logic [D_WIDTH-1:0]  currA_out,
    output logic [D_WIDTH-1:0]  currB_out,
    output logic [D_WIDTH-1:0]  currC_out,
    output logic                foc_valid,
    input  logic                foc_ready,
    output logic                overrun,
    output logic                timeout_err,
    input  logic                err_clr,
    output logic [15:0]         sample_cnt
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    // Q_BITS is carried for the datapath only; the binary point must lie inside the word.
    if (Q_BITS >= D_WIDTH) begin : g_qbits_out_of_range
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG_KP,
        S_CFG_KI,
        S_RUN_WAIT,
        S_RUN_BUSY
    } state_t;

    state_t              state, state_n;
    logic [PERIOD_W-1:0] pcnt;
    logic [PERIOD_W-1:0] reload;
    logic [TW-1:0]       tcnt;
    logic                tick;
    logic                ready_ok;
    logic                tmo;
    logic                latch;

    always_comb begin
        reload   = (period == '0) ? '0 : period - PERIOD_W'(1);
        tick     = ((state == S_RUN_WAIT) || (state == S_RUN_BUSY)) && (pcnt == '0);
        // Ready is only meaningful from the cycle after the valid pulse.
        ready_ok = (state == S_RUN_BUSY) && foc_ready && !foc_valid;
        tmo      = (state == S_RUN_BUSY) && !ready_ok && (tcnt == T_LAST);
        latch    = (state == S_RUN_WAIT) && enable && tick;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        cfg_busy   = 1'b0;
        pid_d_wen  = 1'b0;
        pid_q_wen  = 1'b0;
        pid_d_addr = '0;
        pid_q_addr = '0;
        pid_d_data = '0;
        pid_q_data = '0;
        case (state)
            S_IDLE: begin
                if (cfg_start)                  state_n = S_CFG_KP;
                else if (enable && configured)  state_n = S_RUN_WAIT;
            end
            S_CFG_KP: begin
                cfg_busy   = 1'b1;
                pid_d_wen  = 1'b1;
                pid_q_wen  = 1'b1;
                pid_d_data = cfg_kp_d;
                pid_q_data = cfg_kp_q;
                state_n    = S_CFG_KI;
            end
            S_CFG_KI: begin
                cfg_busy   = 1'b1;
                pid_d_wen  = 1'b1;
                pid_q_wen  = 1'b1;
                pid_d_addr = D_WIDTH'(1);
                pid_q_addr = D_WIDTH'(1);
                pid_d_data = cfg_ki_d;
                pid_q_data = cfg_ki_q;
                state_n    = S_IDLE;
            end
            S_RUN_WAIT: begin
                if (!enable)   state_n = S_IDLE;
                else if (tick) state_n = S_RUN_BUSY;
            end
            S_RUN_BUSY: begin
                if (ready_ok)  state_n = enable ? S_RUN_WAIT : S_IDLE;
                else if (tmo)  state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outside the run states the period counter tracks the reload value, so
    // entering RUN_WAIT starts from max(period,1)-1 without a separate load path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt        <= '0;
            tcnt        <= '0;
            foc_valid   <= 1'b0;
            angle_out   <= '0;
            currA_out   <= '0;
            currB_out   <= '0;
            currC_out   <= '0;
            sample_cnt  <= '0;
            configured  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if ((state == S_RUN_WAIT) || (state == S_RUN_BUSY))
                pcnt <= tick ? reload : pcnt - PERIOD_W'(1);
            else
                pcnt <= reload;

            if (state != S_RUN_BUSY) tcnt <= '0;
            else if (!ready_ok)      tcnt <= tcnt + TW'(1);

            foc_valid <= latch;
            if (latch) begin
                angle_out <= angle_in;
                currA_out <= currA_in;
                currB_out <= currB_in;
                currC_out <= currC_in;
            end

            if (ready_ok)            sample_cnt <= sample_cnt + 16'd1;
            if (state == S_CFG_KI)   configured <= 1'b1;

            if ((state == S_RUN_BUSY) && tick) overrun <= 1'b1;
            else if (err_clr)                  overrun <= 1'b0;

            if (tmo)          timeout_err <= 1'b1;
            else if (err_clr) timeout_err <= 1'b0;
        end
    end

endmodule

// File: doc/foc_loop_sched.md
# foc_loop_sched

Sequencer for the FOC current-control datapath. It loads the d/q PID coefficients through the PID write ports, then runs the loop at a programmable sample period. Each sample it latches angle and phase currents, issues a one-cycle `foc_valid` and waits for `foc_ready`, with overrun and timeout detection. It sits between the sensor/ECU interface and the `top` datapath and owns that datapath's valid/ready and PID write ports.

## Interface
Parameters:
- `D_WIDTH`, 19: datapath word width.
- `Q_BITS`, 15: fractional bits (pass-through; no arithmetic here).
- `PERIOD_W`, 16: width of the sample-period register.
- `TIMEOUT`, 255: max cycles to wait for `foc_ready` after `foc_valid`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request (level).
- `period`  in  PERIOD_W  sample period in cycles; 0 treated as 1.
- `cfg_start`  in  1  pulse: write coefficients; accepted only in IDLE.
- `cfg_kp_d`, `cfg_ki_d`, `cfg_kp_q`, `cfg_ki_q`  in  D_WIDTH  coefficients.
- `cfg_busy`  out  1  high in CFG_KP/CFG_KI.
- `configured`  out  1  set after a complete coefficient load.
- `pid_d_wen`, `pid_q_wen`  out  1  PID coefficient write enables.
- `pid_d_addr`, `pid_q_addr`  out  D_WIDTH  0 = Kp, 1 = Ki.
- `pid_d_data`, `pid_q_data`  out  D_WIDTH  coefficient data.
- `angle_in`, `currA_in`, `currB_in`, `currC_in`  in  D_WIDTH  live sensor values.
- `angle_out`, `currA_out`, `currB_out`, `currC_out`  out  D_WIDTH  sample latched at issue, held until next issue.
- `foc_valid`  out  1  one-cycle start pulse to datapath.
- `foc_ready`  in  1  datapath completion (≥1 cycle high).
- `overrun`  out  1  sticky: tick while busy.
- `timeout_err`  out  1  sticky: no ready within TIMEOUT.
- `err_clr`  in  1  clears sticky flags.
- `sample_cnt`  out  16  completed samples, wraps.

## Operation
- States: IDLE, CFG_KP, CFG_KI, RUN_WAIT, RUN_BUSY.
- IDLE:
  - `cfg_start` → CFG_KP. This has priority over `enable`.
  - Otherwise, `enable && configured` → RUN_WAIT, with the period counter loaded to max(period,1)−1.
- CFG_KP (one cycle): both wen=1, addr=0, data=kp_d/kp_q → CFG_KI.
- CFG_KI (one cycle): wen=1, addr=1, data=ki_d/ki_q → IDLE, and `configured` is set.
- Outside CFG states: wen=0, addr=0, data=0.
- Period counter runs in both RUN states. When it is 0 (tick), it reloads max(period,1)−1; `period` is sampled only at reload.
- Tick in RUN_WAIT:
  - Latch angle/currents into the `*_out` registers.
  - `foc_valid`=1 next cycle.
  - → RUN_BUSY with the timeout counter cleared.
- RUN_BUSY:
  - `foc_ready` is sampled from the cycle after `foc_valid` onward. Ready high → `sample_cnt`+1, then → RUN_WAIT if `enable`, else → IDLE.
  - A tick while in RUN_BUSY sets `overrun`. That sample is skipped: no latch, no valid.
  - Timeout counter reaches TIMEOUT without ready → `timeout_err`=1, → IDLE. The transaction is abandoned and `sample_cnt` is unchanged.
- `enable` low in RUN_WAIT → IDLE next cycle. `enable` low in RUN_BUSY → the current transaction completes (or times out) first.
- `foc_ready` is ignored in IDLE, CFG and RUN_WAIT.
- `cfg_start` outside IDLE is ignored. `configured` stays set until reset.
- `err_clr` clears both sticky flags. If `err_clr` and a set event occur in the same cycle, set wins.

## Timing
- Reset (async assert): state IDLE. All outputs are 0, including `configured`, `sample_cnt`, latched samples and both flags. An in-flight write or transaction is dropped.
- Coefficient load: `cfg_start` sampled at edge N. Kp write is visible in cycle N+1, Ki write in N+2. `configured`=1 and `cfg_busy`=0 from N+3.
- Run start: `enable` sampled in IDLE at edge E. The first `foc_valid` is high in the cycle after edge E+P, where P = max(period,1). Latched samples are the values present at edge E+P.
- Steady state with ready arriving within P−1 cycles: `foc_valid` every P cycles, exactly one cycle wide.
- Ready latency: ready high at edge R → `sample_cnt` updates at R. The next valid is governed only by the free-running period counter.

## Test plan
- Config: `cfg_start` with kp=4096, ki=512 → wen high 2 cycles: addr 0/data 4096, then addr 1/data 512. `configured`=1 on the third cycle.
- Periodic run: period=8, datapath ready 3 cycles after valid, 5 samples → valid exactly every 8 cycles, `sample_cnt`=5, no flags.
- Overrun: period=4, ready 6 cycles after valid → `overrun`=1. The skipped tick produces no valid. Valid spacing is 8.
- Timeout: TIMEOUT=16, ready never asserted → `timeout_err`=1 after 16 busy cycles, state IDLE, `sample_cnt` unchanged. `err_clr` then clears it.
- Enable drop mid-busy: deassert `enable` 1 cycle after valid, ready at +3 → `sample_cnt`+1, IDLE, no further valid.
- Async reset during CFG_KI: wen=0 immediately, `configured`=0. `enable` alone then starts nothing.
